// File: rtl/fpalu_arbiter_if.sv
// fpalu_arbiter_if
//   Bundles the requester-side and FPALU-side signals of fpalu_arbiter.
//   slave  : arbiter view (requests in, FPALU results in, grants/results out)
//   master : environment view (requesters plus the FPALU itself)
// Signals
//   ivalid[1:0]           request valid per port, held until accepted
//   idataa0/1, idatab0/1  operands A/B for port 0 / port 1
//   icontrol0/1           FP opcode for port 0 / port 1
//   oaccept[1:0]          one-cycle pulse, request latched on that port
//   odone[1:0]            one-cycle pulse, result valid for that port
//   oresult               registered result, held between done pulses
//   oerror                qualifies odone, 1 = watchdog abort
//   obusy                 arbiter not idle
//   ofpu_a/b, ofpu_ctrl   latched operands/opcode to the FPALU
//   ofpu_start            FPALU istart level
//   ifpu_ready            FPALU oready
//   ifpu_result           FPALU oresult
interface fpalu_arbiter_if #(
    parameter int CTRL_W = 5
);
    logic [1:0]        ivalid;
    logic [31:0]       idataa0;
    logic [31:0]       idataa1;
    logic [31:0]       idatab0;
    logic [31:0]       idatab1;
    logic [CTRL_W-1:0] icontrol0;
    logic [CTRL_W-1:0] icontrol1;
    logic [1:0]        oaccept;
    logic [1:0]        odone;
    logic [31:0]       oresult;
    logic              oerror;
    logic              obusy;
    logic [31:0]       ofpu_a;
    logic [31:0]       ofpu_b;
    logic [CTRL_W-1:0] ofpu_ctrl;
    logic              ofpu_start;
    logic              ifpu_ready;
    logic [31:0]       ifpu_result;

    modport slave (
        input  ivalid, idataa0, idataa1, idatab0, idatab1, icontrol0, icontrol1,
        input  ifpu_ready, ifpu_result,
        output oaccept, odone, oresult, oerror, obusy,
        output ofpu_a, ofpu_b, ofpu_ctrl, ofpu_start
    );

    modport master (
        output ivalid, idataa0, idataa1, idatab0, idatab1, icontrol0, icontrol1,
        output ifpu_ready, ifpu_result,
        input  oaccept, odone, oresult, oerror, obusy,
        input  ofpu_a, ofpu_b, ofpu_ctrl, ofpu_start
    );
endinterface

// File: rtl/fpalu_arbiter.sv
// fpalu_arbiter
//   Shares one FPALU between two requesters (port 0: pipeline FP stage,
//   port 1: debug/CSR path). Round-robin grant, operand/opcode latch,
//   istart level handshake, result register and watchdog abort.
// Ports
//   iclock    system clock, rising edge
//   ireset_n  asynchronous active-low reset
//   bus       fpalu_arbiter_if slave modport (requesters + FPALU)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no op in flight; grant a pending request
// ISSUE | operands latched, istart raised, watchdog loaded
// WAIT  | istart held; wait for ready or watchdog terminal count
// DONE  | done pulse to the owning port; istart low
module fpalu_arbiter #(
    parameter int          CTRL_W     = 5,
    parameter int          MAX_CYCLES = 31,
    parameter logic [31:0] ERR_RESULT = 32'hEEEE_EEEE
) (
    input  logic            iclock,
    input  logic            ireset_n,
    fpalu_arbiter_if.slave  bus
);

    localparam int WD_W = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic            rr_last;
    logic            owner;
    logic [WD_W-1:0] wd;
    logic            gnt;

    // Lone request always wins; with both pending the port that was not
    // served last time gets the FPALU.
    always_comb begin
        gnt = 1'b0;
        case (bus.ivalid)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~rr_last;
            default: gnt = 1'b0;
        endcase
    end

    assign bus.obusy = (state != IDLE);

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            state          <= IDLE;
            rr_last        <= 1'b1;
            owner          <= 1'b0;
            wd             <= '0;
            bus.oaccept    <= 2'b00;
            bus.odone      <= 2'b00;
            bus.oresult    <= '0;
            bus.oerror     <= 1'b0;
            bus.ofpu_a     <= '0;
            bus.ofpu_b     <= '0;
            bus.ofpu_ctrl  <= '0;
            bus.ofpu_start <= 1'b0;
        end else begin
            bus.oaccept <= 2'b00;
            bus.odone   <= 2'b00;
            case (state)
                IDLE: begin
                    if (|bus.ivalid) begin
                        bus.oaccept    <= gnt ? 2'b10 : 2'b01;
                        bus.ofpu_a     <= gnt ? bus.idataa1   : bus.idataa0;
                        bus.ofpu_b     <= gnt ? bus.idatab1   : bus.idatab0;
                        bus.ofpu_ctrl  <= gnt ? bus.icontrol1 : bus.icontrol0;
                        bus.ofpu_start <= 1'b1;
                        rr_last        <= gnt;
                        owner          <= gnt;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Down-counter: reaches zero on WAIT cycle MAX_CYCLES+1.
                    wd    <= WD_W'(MAX_CYCLES);
                    state <= WAIT;
                end
                WAIT: begin
                    // A ready arriving on the terminal-count cycle still wins.
                    if (bus.ifpu_ready) begin
                        bus.oresult    <= bus.ifpu_result;
                        bus.oerror     <= 1'b0;
                        bus.odone      <= owner ? 2'b10 : 2'b01;
                        bus.ofpu_start <= 1'b0;
                        state          <= DONE;
                    end else if (wd == '0) begin
                        bus.oresult    <= ERR_RESULT;
                        bus.oerror     <= 1'b1;
                        bus.odone      <= owner ? 2'b10 : 2'b01;
                        bus.ofpu_start <= 1'b0;
                        state          <= DONE;
                    end else begin
                        wd <= wd - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state          <= IDLE;
                    bus.ofpu_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpalu_arbiter.sv
module tb_fpalu_arbiter;

    localparam int CTRL_W = 5;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    fpalu_arbiter_if #(.CTRL_W(CTRL_W)) bus ();

    fpalu_arbiter #(
        .CTRL_W     (CTRL_W),
        .MAX_CYCLES (31),
        .ERR_RESULT (32'hEEEE_EEEE)
    ) dut (
        .iclock   (clk),
        .ireset_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPALU model: ready rises lat cycles after istart goes high, drops
    // when istart drops; lat == 0 means it never answers.
    int          lat     = 0;
    int          fpu_cnt = 0;
    logic [31:0] fpu_res = '0;
    assign bus.ifpu_result = fpu_res;

    always @(posedge clk) begin
        if (!bus.ofpu_start) begin
            fpu_cnt        <= 0;
            bus.ifpu_ready <= 1'b0;
        end else begin
            fpu_cnt        <= fpu_cnt + 1;
            bus.ifpu_ready <= (lat > 0) && (fpu_cnt + 1 >= lat);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string tag, input logic [1:0] exp, input int exp_cyc);
        int c;
        c = 0;
        while (bus.oaccept == 2'b00 && c < 60) begin
            tick();
            c++;
        end
        chk({tag, "_accept"}, 32'(bus.oaccept), 32'(exp));
        chk({tag, "_acc_lat"}, 32'(c), 32'(exp_cyc));
        chk({tag, "_busy"}, 32'(bus.obusy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp, input logic [31:0] res,
                             input logic err, input int exp_cyc);
        int c;
        c = 0;
        while (bus.odone == 2'b00 && c < 100) begin
            tick();
            c++;
        end
        chk({tag, "_done"}, 32'(bus.odone), 32'(exp));
        chk({tag, "_result"}, bus.oresult, res);
        chk({tag, "_error"}, 32'(bus.oerror), 32'(err));
        chk({tag, "_done_lat"}, 32'(c), 32'(exp_cyc));
        chk({tag, "_start_lo"}, 32'(bus.ofpu_start), 32'd0);
        tick();
        chk({tag, "_pulse"}, 32'(bus.odone), 32'd0);
        chk({tag, "_held"}, bus.oresult, res);
    endtask

    // istart gap and operand stability monitor
    initial begin
        int          low_cnt;
        logic        seen;
        logic        prev_start;
        logic [31:0] prev_a;
        logic [31:0] prev_b;
        logic [CTRL_W-1:0] prev_c;
        low_cnt    = 0;
        seen       = 1'b0;
        prev_start = 1'b0;
        prev_a     = '0;
        prev_b     = '0;
        prev_c     = '0;
        forever begin
            @(negedge clk);
            if (bus.ofpu_start === 1'b1) begin
                if (prev_start) begin
                    chk("stable_a", bus.ofpu_a, prev_a);
                    chk("stable_b", bus.ofpu_b, prev_b);
                    chk("stable_ctrl", 32'(bus.ofpu_ctrl), 32'(prev_c));
                end else if (seen) begin
                    chk("start_gap_ge2", 32'(low_cnt >= 2), 32'd1);
                end
                seen    = 1'b1;
                low_cnt = 0;
            end else begin
                low_cnt++;
            end
            prev_start = (bus.ofpu_start === 1'b1);
            prev_a     = bus.ofpu_a;
            prev_b     = bus.ofpu_b;
            prev_c     = bus.ofpu_ctrl;
        end
    end

    logic [1:0] t3_gnt [4];

    initial begin
        t3_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst_n         = 1'b0;
        bus.ivalid    = 2'b00;
        bus.idataa0   = '0;
        bus.idataa1   = '0;
        bus.idatab0   = '0;
        bus.idatab1   = '0;
        bus.icontrol0 = '0;
        bus.icontrol1 = '0;

        // reset state
        tick();
        tick();
        chk("rst_busy", 32'(bus.obusy), 32'd0);
        chk("rst_start", 32'(bus.ofpu_start), 32'd0);
        chk("rst_accept", 32'(bus.oaccept), 32'd0);
        chk("rst_done", 32'(bus.odone), 32'd0);
        chk("rst_result", bus.oresult, 32'd0);
        chk("rst_error", 32'(bus.oerror), 32'd0);
        chk("rst_fpu_a", bus.ofpu_a, 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: port 0 FOPADD 1.0 + 2.0 = 3.0, ready after 7 cycles
        bus.idataa0   = 32'h3f80_0000;
        bus.idatab0   = 32'h4000_0000;
        bus.icontrol0 = 5'd0;
        fpu_res       = 32'h4040_0000;
        lat           = 7;
        bus.ivalid    = 2'b01;
        wait_accept("t1", 2'b01, 1);
        chk("t1_fpu_a", bus.ofpu_a, 32'h3f80_0000);
        chk("t1_fpu_b", bus.ofpu_b, 32'h4000_0000);
        chk("t1_fpu_ctrl", 32'(bus.ofpu_ctrl), 32'd0);
        chk("t1_start", 32'(bus.ofpu_start), 32'd1);
        bus.ivalid = 2'b00;
        wait_done("t1", 2'b01, 32'h4040_0000, 1'b0, 8);

        // single request on port 1: 3.0 - 1.0 = 2.0, ready after 3
        bus.idataa1   = 32'h4040_0000;
        bus.idatab1   = 32'h3f80_0000;
        bus.icontrol1 = 5'd1;
        fpu_res       = 32'h4000_0000;
        lat           = 3;
        bus.ivalid    = 2'b10;
        wait_accept("t1b", 2'b10, 1);
        chk("t1b_fpu_ctrl", 32'(bus.ofpu_ctrl), 32'd1);
        bus.ivalid = 2'b00;
        wait_done("t1b", 2'b10, 32'h4000_0000, 1'b0, 4);

        // T2: contention, port 0 (2.0*3.0) then port 1 (10.0/2.0), back-to-back
        bus.idataa0   = 32'h4000_0000;
        bus.idatab0   = 32'h4040_0000;
        bus.icontrol0 = 5'd2;
        bus.idataa1   = 32'h4120_0000;
        bus.idatab1   = 32'h4000_0000;
        bus.icontrol1 = 5'd3;
        fpu_res       = 32'h40c0_0000;
        lat           = 5;
        bus.ivalid    = 2'b11;
        wait_accept("t2a", 2'b01, 1);
        chk("t2a_fpu_a", bus.ofpu_a, 32'h4000_0000);
        chk("t2a_fpu_ctrl", 32'(bus.ofpu_ctrl), 32'd2);
        bus.ivalid = 2'b10;
        wait_done("t2a", 2'b01, 32'h40c0_0000, 1'b0, 6);
        fpu_res = 32'h40a0_0000;
        lat     = 10;
        wait_accept("t2b", 2'b10, 1);
        chk("t2b_fpu_a", bus.ofpu_a, 32'h4120_0000);
        bus.ivalid    = 2'b00;
        // requester-side changes during the op must not reach the FPALU
        bus.idataa1   = 32'hdead_beef;
        bus.idatab1   = 32'h0bad_f00d;
        bus.icontrol1 = 5'd31;
        wait_done("t2b", 2'b10, 32'h40a0_0000, 1'b0, 11);
        chk("t2b_a_kept", bus.ofpu_a, 32'h4120_0000);
        chk("t2b_ctrl_kept", 32'(bus.ofpu_ctrl), 32'd3);

        // T3: port 0 always valid, port 1 valid from op 2 -> 0,1,0,1
        bus.idataa0   = 32'h0000_0001;
        bus.idatab0   = 32'h0000_0002;
        bus.icontrol0 = 5'd4;
        bus.idataa1   = 32'h0000_0003;
        bus.idatab1   = 32'h0000_0004;
        bus.icontrol1 = 5'd5;
        lat           = 2;
        bus.ivalid    = 2'b01;
        for (int i = 0; i < 4; i++) begin
            fpu_res = 32'h0000_00a0 + 32'(i);
            wait_accept($sformatf("t3_op%0d", i), t3_gnt[i], 1);
            chk($sformatf("t3_op%0d_fpu_a", i), bus.ofpu_a,
                (t3_gnt[i] == 2'b01) ? 32'h0000_0001 : 32'h0000_0003);
            if (i == 0) bus.ivalid = 2'b11;
            if (i == 3) bus.ivalid = 2'b00;
            wait_done($sformatf("t3_op%0d", i), t3_gnt[i], 32'h0000_00a0 + 32'(i), 1'b0, 3);
        end
        bus.ivalid = 2'b00;
        tick();
        chk("t3_idle", 32'(bus.obusy), 32'd0);

        // T4: FPALU never answers -> abort after MAX_CYCLES+1 WAIT cycles
        lat        = 0;
        fpu_res    = 32'h1111_1111;
        bus.ivalid = 2'b01;
        wait_accept("t4", 2'b01, 1);
        bus.ivalid = 2'b00;
        wait_done("t4", 2'b01, 32'heeee_eeee, 1'b1, 33);

        // ready exactly on the terminal-count cycle is a normal result
        lat        = 32;
        fpu_res    = 32'h1234_5678;
        bus.ivalid = 2'b10;
        wait_accept("t4b", 2'b10, 1);
        bus.ivalid = 2'b00;
        wait_done("t4b", 2'b10, 32'h1234_5678, 1'b0, 33);

        // T6: reset while in WAIT
        lat        = 0;
        bus.ivalid = 2'b01;
        wait_accept("t6", 2'b01, 1);
        bus.ivalid = 2'b00;
        repeat (5) tick();
        chk("t6_start_pre", 32'(bus.ofpu_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.obusy), 32'd0);
        chk("t6_start", 32'(bus.ofpu_start), 32'd0);
        chk("t6_result", bus.oresult, 32'd0);
        chk("t6_error", 32'(bus.oerror), 32'd0);
        chk("t6_fpu_a", bus.ofpu_a, 32'd0);
        chk("t6_fpu_ctrl", 32'(bus.ofpu_ctrl), 32'd0);
        chk("t6_done", 32'(bus.odone), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t6_no_done%0d", i), 32'(bus.odone), 32'd0);
        end

        // after reset rr_last=1 again: both valid -> port 0 first
        bus.idataa0   = 32'h3f80_0000;
        bus.icontrol0 = 5'd6;
        bus.idataa1   = 32'h4000_0000;
        bus.icontrol1 = 5'd7;
        lat           = 4;
        fpu_res       = 32'h3f80_0000;
        bus.ivalid    = 2'b11;
        wait_accept("t6a", 2'b01, 1);
        bus.ivalid = 2'b10;
        wait_done("t6a", 2'b01, 32'h3f80_0000, 1'b0, 5);
        fpu_res = 32'h4000_0000;
        wait_accept("t6b", 2'b10, 1);
        chk("t6b_fpu_a", bus.ofpu_a, 32'h4000_0000);
        bus.ivalid = 2'b00;
        wait_done("t6b", 2'b10, 32'h4000_0000, 1'b0, 5);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
